// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, default bit timing and the
// command framing bytes recognised by the downstream parser.
package uart_pkg;

    typedef enum logic [2:0] {
        RX_IDLE  = 3'd0,
        RX_START = 3'd1,
        RX_DATA  = 3'd2,
        RX_STOP  = 3'd3,
        RX_BREAK = 3'd4
    } rx_state_t;

    // 50 MHz system clock, 115200 baud
    localparam int DEFAULT_CLKS_PER_BIT = 434;

    localparam logic [7:0] CMD_START = 8'h73;  // 's'
    localparam logic [7:0] CMD_END   = 8'h65;  // 'e'

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input; reset value is
// chosen by the instantiating module so an idle line does not look active.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= RESET_VAL;
            o_q    <= RESET_VAL;
        end else begin
            r_meta <= i_d;
            o_q    <= r_meta;
        end
    end

endmodule

// File: rtl/uart_serial_rx.sv
// 8N1 UART receiver with a single-entry holding register, framing-error and
// overrun reporting, and a valid/ready output handshake.
module uart_serial_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_rxd,
    input  logic       from_uart_ready,
    output logic [7:0] from_uart_data,
    output logic       from_uart_valid,
    output logic       from_uart_error
);

    // Output handshake: a byte moves to the consumer on every rising edge where
    // from_uart_valid and from_uart_ready are both high; while valid is high
    // without ready, data and error hold still.

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] HALF_CNT = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(CLKS_PER_BIT - 1);

    logic            w_rxs;
    logic            w_xfer;
    rx_state_t       r_state;
    logic [CW-1:0]   r_cnt;
    logic [2:0]      r_idx;
    logic [7:0]      r_shift;
    logic            r_done;
    logic            r_done_fe;
    logic            r_ovr;

    sync_2ff #(
        .RESET_VAL(1'b1)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .i_d (uart_rxd),
        .o_q (w_rxs)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= RX_IDLE;
            r_cnt     <= '0;
            r_idx     <= '0;
            r_shift   <= '0;
            r_done    <= 1'b0;
            r_done_fe <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                RX_IDLE: begin
                    if (!w_rxs) begin
                        r_state <= RX_START;
                        r_cnt   <= '0;
                    end
                end
                RX_START: begin
                    // Re-check the line mid start bit to reject short glitches
                    if (r_cnt == HALF_CNT) begin
                        r_cnt <= '0;
                        r_idx <= '0;
                        r_state <= w_rxs ? RX_IDLE : RX_DATA;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (r_cnt == FULL_CNT) begin
                        r_cnt          <= '0;
                        r_shift[r_idx] <= w_rxs;
                        if (r_idx == 3'd7) begin
                            r_state <= RX_STOP;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (r_cnt == FULL_CNT) begin
                        r_cnt     <= '0;
                        r_done    <= 1'b1;
                        r_done_fe <= ~w_rxs;
                        r_state   <= w_rxs ? RX_IDLE : RX_BREAK;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                RX_BREAK: begin
                    if (w_rxs) begin
                        r_state <= RX_IDLE;
                    end
                end
                default: begin
                    r_state <= RX_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign w_xfer = from_uart_valid & from_uart_ready;

    // r_shift stays untouched for at least half a bit after the stop sample,
    // so it can be loaded directly one cycle later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            from_uart_data  <= '0;
            from_uart_valid <= 1'b0;
            from_uart_error <= 1'b0;
            r_ovr           <= 1'b0;
        end else if (r_done) begin
            if (!from_uart_valid || w_xfer) begin
                from_uart_data  <= r_shift;
                from_uart_valid <= 1'b1;
                from_uart_error <= r_done_fe | r_ovr;
                r_ovr           <= 1'b0;
            end else begin
                r_ovr <= 1'b1;
            end
        end else if (w_xfer) begin
            from_uart_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_serial_rx.sv
// Randomized self-checking bench for uart_serial_rx: a frame driver feeds a
// reference model that fills an expected queue, a monitor pops on transfers.
`timescale 1ns/1ps
module tb_uart_serial_rx;
    import uart_pkg::*;

    localparam int CPB = 16;
    localparam int LATENCY = 3 + CPB / 2 + 9 * CPB + 1;

    logic       clk;
    logic       rst;
    logic       uart_rxd;
    logic       from_uart_ready;
    logic [7:0] from_uart_data;
    logic       from_uart_valid;
    logic       from_uart_error;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int t_start = 0;
    int last_rise = 0;
    int valid_hi_cycles = 0;

    // {error, data}
    logic [8:0] exp_q[$];
    bit m_full = 0;
    bit m_ovr = 0;

    logic       prev_valid = 1'b0;
    logic       prev_ready = 1'b0;
    logic [7:0] prev_data = '0;
    logic       prev_err = 1'b0;

    uart_serial_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk             (clk),
        .rst             (rst),
        .uart_rxd        (uart_rxd),
        .from_uart_ready (from_uart_ready),
        .from_uart_data  (from_uart_data),
        .from_uart_valid (from_uart_valid),
        .from_uart_error (from_uart_error)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: one holding slot, drained only while ready is high.
    task automatic model_byte(input logic [7:0] b, input logic fe);
        if (!m_full) begin
            exp_q.push_back({fe | m_ovr, b});
            m_ovr = 0;
            m_full = !from_uart_ready;
        end else begin
            m_ovr = 1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        uart_rxd = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("reset_data", {24'd0, from_uart_data}, 32'd0);
            check("reset_valid", {31'd0, from_uart_valid}, 32'd0);
            check("reset_error", {31'd0, from_uart_error}, 32'd0);
        end
        rst = 1'b0;
        m_full = 0;
        m_ovr = 0;
    endtask

    // abort_bit >= 0 asserts reset halfway through that data bit
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int abort_bit);
        logic [9:0] bits;
        bits = {stop_bit, b, 1'b0};
        @(negedge clk);
        t_start = cyc;
        if (abort_bit < 0) model_byte(b, ~stop_bit);
        for (int i = 0; i < 10; i++) begin
            uart_rxd = bits[i];
            if (abort_bit >= 0 && i == abort_bit + 1) begin
                repeat (CPB / 2) @(negedge clk);
                do_reset();
                return;
            end
            if (i < 9) repeat (CPB) @(negedge clk);
            else repeat (CPB - 1) @(negedge clk);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            prev_valid = 1'b0;
            prev_ready = 1'b0;
        end else begin
            if (from_uart_valid) valid_hi_cycles++;
            if (from_uart_valid && !prev_valid) last_rise = cyc;
            if (prev_valid && !prev_ready && from_uart_valid) begin
                check("hold_data_stable", {24'd0, from_uart_data}, {24'd0, prev_data});
                check("hold_error_stable", {31'd0, from_uart_error}, {31'd0, prev_err});
            end
            if (from_uart_valid && from_uart_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_byte: got data %0h error %0b, expected none", from_uart_data, from_uart_error);
                end else begin
                    logic [8:0] e;
                    e = exp_q.pop_front();
                    check("rx_data", {24'd0, from_uart_data}, {24'd0, e[7:0]});
                    check("rx_error", {31'd0, from_uart_error}, {31'd0, e[8]});
                end
            end
            prev_valid = from_uart_valid;
            prev_ready = from_uart_ready;
            prev_data  = from_uart_data;
            prev_err   = from_uart_error;
        end
    end

    initial begin
        logic [7:0] seq4 [4];
        seq4 = '{8'h01, 8'h00, 8'h03, 8'h46};
        rst = 1'b1;
        uart_rxd = 1'b1;
        from_uart_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_state", {29'd0, dut.r_state}, {29'd0, RX_IDLE});
        do_reset();
        repeat (5) @(negedge clk);

        // single command byte, latency and one-cycle pulse
        valid_hi_cycles = 0;
        send_frame(CMD_START, 1'b1, -1);
        repeat (4) @(negedge clk);
        check("latency", last_rise - t_start, LATENCY);
        check("pulse_width", valid_hi_cycles, 1);
        repeat (10) @(negedge clk);

        // back-to-back frames
        foreach (seq4[i]) send_frame(seq4[i], 1'b1, -1);
        repeat (30) @(negedge clk);

        // framing error with a held break, then a clean frame
        send_frame(8'hA5, 1'b0, -1);
        repeat (40) @(negedge clk);
        uart_rxd = 1'b1;
        repeat (20) @(negedge clk);
        send_frame(CMD_END, 1'b1, -1);
        repeat (30) @(negedge clk);

        // short glitch on the idle line
        valid_hi_cycles = 0;
        uart_rxd = 1'b0;
        repeat (4) @(negedge clk);
        uart_rxd = 1'b1;
        repeat (40) @(negedge clk);
        check("glitch_no_valid", valid_hi_cycles, 0);
        check("glitch_state_idle", {29'd0, dut.r_state}, {29'd0, RX_IDLE});

        // overrun: second byte dropped, flagged on the next delivered one
        from_uart_ready = 1'b0;
        send_frame(8'h11, 1'b1, -1);
        send_frame(8'h22, 1'b1, -1);
        repeat (20) @(negedge clk);
        check("overrun_still_held", {31'd0, from_uart_valid}, 32'd1);
        from_uart_ready = 1'b1;
        m_full = 0;
        repeat (5) @(negedge clk);
        send_frame(8'h33, 1'b1, -1);
        repeat (30) @(negedge clk);

        // reset mid-frame, then a fresh frame
        send_frame(8'h5A, 1'b1, 4);
        repeat (40) @(negedge clk);
        check("post_reset_state", {29'd0, dut.r_state}, {29'd0, RX_IDLE});
        send_frame(8'h3C, 1'b1, -1);
        repeat (30) @(negedge clk);

        // randomized frames with occasional framing errors and gaps
        for (int n = 0; n < 12; n++) begin
            logic [7:0] b;
            logic fe;
            b = 8'($urandom_range(0, 255));
            fe = ($urandom_range(0, 3) == 0);
            send_frame(b, ~fe, -1);
            if (fe) begin
                repeat ($urandom_range(20, 40)) @(negedge clk);
                uart_rxd = 1'b1;
                repeat ($urandom_range(4, 20)) @(negedge clk);
            end else begin
                repeat ($urandom_range(0, 20)) @(negedge clk);
            end
        end
        repeat (40) @(negedge clk);

        check("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
